// File: rtl/cpu_op_sequencer.sv
// Command front-end for the cpu datapath: buffers packed instructions in a FIFO,
// presents each one to the cpu for HOLD_CYCLES clocks, then hands back the captured result.
module cpu_op_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [48:0]      in_instr,
  output logic [4:0]       cpu_addrA,
  output logic [4:0]       cpu_addrB,
  output logic [31:0]      cpu_data,
  output logic             cpu_asel,
  output logic             cpu_bsel,
  output logic [1:0]       cpu_opsel,
  output logic [1:0]       cpu_outsel,
  output logic             cpu_oen,
  input  logic [31:0]      cpu_out,
  input  logic             cpu_over,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_over,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef struct packed {
    logic        oen;
    logic        bsel;
    logic        asel;
    logic [1:0]  outsel;
    logic [1:0]  opsel;
    logic [4:0]  addr_a;
    logic [4:0]  addr_b;
    logic [31:0] data;
  } instr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, REPORT} state_t;

  instr_t        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  state_t        state_reg;
  logic [HW-1:0] hold_reg;
  instr_t        head;
  logic          push;
  logic          pop;

  assign in_ready = (count_reg != (AW+1)'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_reg == IDLE) && (count_reg != '0);
  assign head     = fifo_mem[rd_ptr_reg];
  assign busy     = (state_reg != IDLE) || (count_reg != '0);

  // Storage carries no reset so it maps onto plain RAM; validity lives in count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= instr_t'(in_instr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The cpu_* registers double as the instruction register, so the cpu sees
  // only flop outputs and returns to NOP in the same edge that captures the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      hold_reg   <= '0;
      cpu_addrA  <= '0;
      cpu_addrB  <= '0;
      cpu_data   <= '0;
      cpu_asel   <= 1'b0;
      cpu_bsel   <= 1'b0;
      cpu_opsel  <= '0;
      cpu_outsel <= '0;
      cpu_oen    <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_over   <= 1'b0;
      done_count <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            cpu_addrA  <= head.addr_a;
            cpu_addrB  <= head.addr_b;
            cpu_data   <= head.data;
            cpu_asel   <= head.asel;
            cpu_bsel   <= head.bsel;
            cpu_opsel  <= head.opsel;
            cpu_outsel <= head.outsel;
            cpu_oen    <= head.oen;
            hold_reg   <= '0;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          if (hold_reg == HW'(HOLD_CYCLES - 1)) begin
            res_data   <= cpu_out;
            res_over   <= cpu_over;
            res_valid  <= 1'b1;
            cpu_addrA  <= '0;
            cpu_addrB  <= '0;
            cpu_data   <= '0;
            cpu_asel   <= 1'b0;
            cpu_bsel   <= 1'b0;
            cpu_opsel  <= '0;
            cpu_outsel <= '0;
            cpu_oen    <= 1'b0;
            state_reg  <= REPORT;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            done_count <= done_count + 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
